// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Single-port BRAM access controller shared by the instruction-fetch master
//   (if_*) and the data load/store master (dm_*). One transaction is in flight
//   at a time. The fixed BRAM read latency is counted internally, so the
//   masters only see req/gnt/rvalid (or wdone) handshakes.
//
//   Optional build macro: ARB_RR_EN
//     defined   -> round-robin between the two masters on a tie
//     undefined -> fixed priority, dm wins every tie
//
//   Ports
//     clk, reset_n             clock, asynchronous active-low reset
//     if_req/if_addr           fetch request (held until if_gnt)
//     if_gnt/if_rvalid/if_rdata fetch grant pulse, data-valid pulse, data
//     dm_req/dm_we/dm_addr/dm_wdata  data request (held until dm_gnt)
//     dm_gnt/dm_rvalid/dm_rdata/dm_wdone  data grant, load valid, load data,
//                              store committed
//     mem_en/mem_ren/mem_wen/mem_addr/mem_din/mem_dout  BRAM port
//     busy                     high while a transaction is in flight
module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_wdone,
  output logic              mem_en,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(RD_LAT - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;      // 1 = dm owns the port
  logic              if_gnt_q, if_gnt_d, dm_gnt_q, dm_gnt_d;
  logic              if_rvalid_q, if_rvalid_d, dm_rvalid_q, dm_rvalid_d;
  logic              dm_wdone_q, dm_wdone_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic              mem_en_q, mem_en_d, mem_ren_q, mem_ren_d;
  logic              mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic              pick_dm;

`ifdef ARB_RR_EN
  logic last_owner_q, last_owner_d;         // 1 = dm, resets to if
  // On a tie the port that was not served last wins.
  assign pick_dm = dm_req && (!if_req || !last_owner_q);
`else
  assign pick_dm = dm_req;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    if_gnt_d    = 1'b0;
    dm_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    dm_wdone_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    mem_en_d    = mem_en_q;
    mem_ren_d   = mem_ren_q;
    mem_wen_d   = mem_wen_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
`ifdef ARB_RR_EN
    last_owner_d = last_owner_q;
`endif
    case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          mem_en_d = 1'b1;
          owner_d  = pick_dm;
`ifdef ARB_RR_EN
          last_owner_d = pick_dm;
`endif
          if (pick_dm) begin
            dm_gnt_d   = 1'b1;
            mem_addr_d = dm_addr;
          end else begin
            if_gnt_d   = 1'b1;
            mem_addr_d = if_addr;
          end
          if (pick_dm && dm_we) begin
            mem_wen_d = 1'b1;
            mem_ren_d = 1'b0;
            mem_din_d = dm_wdata;
            state_d   = WR_DONE;
          end else begin
            mem_ren_d = 1'b1;
            mem_wen_d = 1'b0;
            cnt_d     = CNT_INIT;
            state_d   = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Address has been stable for RD_LAT cycles: mem_dout is valid.
          if (owner_q) begin
            dm_rdata_d  = mem_dout;
            dm_rvalid_d = 1'b1;
          end else begin
            if_rdata_d  = mem_dout;
            if_rvalid_d = 1'b1;
          end
          mem_en_d  = 1'b0;
          mem_ren_d = 1'b0;
          state_d   = IDLE;
        end
      end
      WR_DONE: begin
        mem_en_d   = 1'b0;
        mem_wen_d  = 1'b0;
        dm_wdone_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      if_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      dm_wdone_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_ren_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      if_gnt_q    <= if_gnt_d;
      dm_gnt_q    <= dm_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      dm_wdone_q  <= dm_wdone_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_ren_q   <= mem_ren_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_owner_q <= 1'b0;
    else          last_owner_q <= last_owner_d;
  end
`endif

  assign if_gnt    = if_gnt_q;
  assign dm_gnt    = dm_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign dm_rvalid = dm_rvalid_q;
  assign dm_wdone  = dm_wdone_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_ren   = mem_ren_q;
  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: u0 (RD_LAT=3) runs the directed sequence,
// u1 (RD_LAT=1) runs back-to-back fetches. Read data is checked against a
// per-master queue filled when the request is driven.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  always #5 clk = ~clk;

  // u0 signals
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [15:0] if_addr = '0, dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, dm_wdone;
  logic [31:0] if_rdata, dm_rdata, mem_din, mem_dout;
  logic        mem_en, mem_ren, mem_wen, busy;
  logic [15:0] mem_addr;
  logic [31:0] mem [256];

  // u1 signals
  logic        b_if_req = 1'b0;
  logic [15:0] b_if_addr = '0;
  logic        b_if_gnt, b_if_rvalid, b_dm_gnt, b_dm_rvalid, b_dm_wdone;
  logic [31:0] b_if_rdata, b_dm_rdata, b_mem_din, b_mem_dout;
  logic        b_mem_en, b_mem_ren, b_mem_wen, b_busy;
  logic [15:0] b_mem_addr;
  logic [31:0] b_mem [256];

  int errors = 0;
  int checks = 0;
  logic [31:0] if_q[$], dm_q[$], b_q[$];
  logic dm_first;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(3)) u0 (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .dm_wdone(dm_wdone),
    .mem_en(mem_en), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(1)) u1 (
    .clk(clk), .reset_n(reset_n),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .dm_req(1'b0), .dm_we(1'b0), .dm_addr(16'h0), .dm_wdata(32'h0),
    .dm_gnt(b_dm_gnt), .dm_rvalid(b_dm_rvalid), .dm_rdata(b_dm_rdata),
    .dm_wdone(b_dm_wdone),
    .mem_en(b_mem_en), .mem_ren(b_mem_ren), .mem_wen(b_mem_wen),
    .mem_addr(b_mem_addr), .mem_din(b_mem_din), .mem_dout(b_mem_dout),
    .busy(b_busy)
  );

  // BRAM models: the arbiter's mem_addr register is the BRAM address
  // register, so read data follows the held address.
  always @(posedge clk) if (mem_en && mem_wen) mem[mem_addr[7:0]] <= mem_din;
  assign mem_dout   = mem[mem_addr[7:0]];
  assign b_mem_dout = b_mem[b_mem_addr[7:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor and one-hot handshake checks.
  always @(negedge clk) begin
    if (if_rvalid) begin
      if (if_q.size() == 0) chk1("if_rvalid_unexpected", if_rvalid, 1'b0);
      else chk("if_rdata_sb", if_rdata, if_q.pop_front());
    end
    if (dm_rvalid) begin
      if (dm_q.size() == 0) chk1("dm_rvalid_unexpected", dm_rvalid, 1'b0);
      else chk("dm_rdata_sb", dm_rdata, dm_q.pop_front());
    end
    if (b_if_rvalid) begin
      if (b_q.size() == 0) chk1("b_rvalid_unexpected", b_if_rvalid, 1'b0);
      else chk("b_rdata_sb", b_if_rdata, b_q.pop_front());
    end
    if (reset_n) begin
      chk1("gnt_excl", if_gnt & dm_gnt, 1'b0);
      chk1("rvalid_excl", if_rvalid & (dm_rvalid | dm_wdone), 1'b0);
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]   = 32'h0;
      b_mem[i] = 32'h0;
    end
    mem[8'h40] = 32'h8C010004;
    for (int i = 0; i < 4; i++) b_mem[i] = 32'hA0 + 32'(i);

    // Reset state
    tick();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_mem_en", mem_en, 1'b0);
    chk1("rst_if_gnt", if_gnt, 1'b0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
    reset_n = 1'b1;
    tick();

    // Fetch from 0x0040 with RD_LAT=3
    if_req = 1'b1; if_addr = 16'h0040;
    tick();
    chk1("rd_if_gnt", if_gnt, 1'b1);
    chk1("rd_ren_c1", mem_ren, 1'b1);
    chk("rd_mem_addr", {16'h0, mem_addr}, 32'h40);
    chk1("rd_busy", busy, 1'b1);
    if_req = 1'b0;
    if_q.push_back(32'h8C010004);
    tick();
    chk1("rd_gnt_pulse", if_gnt, 1'b0);
    chk1("rd_ren_c2", mem_ren, 1'b1);
    tick();
    chk1("rd_ren_c3", mem_ren, 1'b1);
    chk1("rd_rvalid_early", if_rvalid, 1'b0);
    tick();
    chk1("rd_rvalid", if_rvalid, 1'b1);
    chk("rd_rdata", if_rdata, 32'h8C010004);
    chk1("rd_busy_done", busy, 1'b0);
    chk1("rd_ren_off", mem_ren, 1'b0);

    // Store 0xDEADBEEF to 0x0010, then load it back
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0010; dm_wdata = 32'hDEADBEEF;
    tick();
    chk1("wr_dm_gnt", dm_gnt, 1'b1);
    chk1("wr_wen", mem_wen, 1'b1);
    chk1("wr_ren", mem_ren, 1'b0);
    chk("wr_din", mem_din, 32'hDEADBEEF);
    dm_req = 1'b0; dm_we = 1'b0;
    tick();
    chk1("wr_wdone", dm_wdone, 1'b1);
    chk1("wr_wen_off", mem_wen, 1'b0);
    chk1("wr_busy_done", busy, 1'b0);
    dm_req = 1'b1;
    tick();
    chk1("ld_dm_gnt", dm_gnt, 1'b1);
    dm_req = 1'b0;
    dm_q.push_back(32'hDEADBEEF);
    tick(); tick(); tick();
    chk1("ld_rvalid", dm_rvalid, 1'b1);
    chk("ld_rdata", dm_rdata, 32'hDEADBEEF);

    // Tie: both masters request together (last owner is dm here)
`ifdef ARB_RR_EN
    dm_first = 1'b0;
`else
    dm_first = 1'b1;
`endif
    if_req = 1'b1; if_addr = 16'h0040;
    dm_req = 1'b1; dm_addr = 16'h0010;
    tick();
    chk1("tie_dm_gnt", dm_gnt, dm_first);
    chk1("tie_if_gnt", if_gnt, !dm_first);
    if (dm_first) begin dm_req = 1'b0; dm_q.push_back(32'hDEADBEEF); end
    else          begin if_req = 1'b0; if_q.push_back(32'h8C010004); end
    tick(); tick(); tick();
    chk1("tie_win_rvalid", dm_first ? dm_rvalid : if_rvalid, 1'b1);
    chk1("tie_lose_wait", dm_first ? if_gnt : dm_gnt, 1'b0);
    tick();
    chk1("tie_lose_gnt", dm_first ? if_gnt : dm_gnt, 1'b1);
    if (dm_first) begin if_req = 1'b0; if_q.push_back(32'h8C010004); end
    else          begin dm_req = 1'b0; dm_q.push_back(32'hDEADBEEF); end
    tick(); tick(); tick();
    chk1("tie_lose_rvalid", dm_first ? if_rvalid : dm_rvalid, 1'b1);

    // Reset during a read: outputs clear at once, no rvalid afterwards
    if_req = 1'b1; if_addr = 16'h0040;
    tick();
    if_req = 1'b0;
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_mem_en", mem_en, 1'b0);
    chk1("arst_mem_ren", mem_ren, 1'b0);
    chk("arst_mem_addr", {16'h0, mem_addr}, 32'h0);
    chk("arst_if_rdata", if_rdata, 32'h0);
    chk("arst_dm_rdata", dm_rdata, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("arst_no_rvalid", if_rvalid, 1'b0);
    end
    reset_n = 1'b1;
    tick();
    chk1("arst_after_idle", if_rvalid, 1'b0);
    if_req = 1'b1;
    tick();
    chk1("arst_new_gnt", if_gnt, 1'b1);
    if_req = 1'b0;
    if_q.push_back(32'h8C010004);
    tick(); tick(); tick();
    chk1("arst_new_rvalid", if_rvalid, 1'b1);

    // Request pulsed while busy then withdrawn: never granted
    dm_req = 1'b1; dm_addr = 16'h0010;
    tick();
    chk1("wd_dm_gnt", dm_gnt, 1'b1);
    dm_req = 1'b0;
    dm_q.push_back(32'hDEADBEEF);
    if_req = 1'b1; if_addr = 16'h0077;
    tick();
    if_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk1("wd_no_if_gnt", if_gnt, 1'b0);
      chk1("wd_addr_not_77", mem_addr == 16'h0077, 1'b0);
      tick();
    end

    // RD_LAT=1 back-to-back fetches 0..3
    for (int i = 0; i < 4; i++) begin
      b_if_req = 1'b1; b_if_addr = 16'(i);
      tick();
      chk1("b_gnt", b_if_gnt, 1'b1);
      chk1("b_mem_en", b_mem_en, 1'b1);
      b_q.push_back(32'hA0 + 32'(i));
      if (i == 3) b_if_req = 1'b0;
      else        b_if_addr = 16'(i + 1);
      tick();
      chk1("b_rvalid", b_if_rvalid, 1'b1);
      chk1("b_en_gap", b_mem_en, 1'b0);
    end

    tick(); tick();
    chk("if_q_drained", 32'(if_q.size()), 32'd0);
    chk("dm_q_drained", 32'(dm_q.size()), 32'd0);
    chk("b_q_drained", 32'(b_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
